// File: rtl/vproc_pkg.sv
// Shared types for the vector dispatcher: execution-unit encoding and slot states.
package vproc_pkg;

  typedef enum logic [2:0] {
    UNIT_LSU  = 3'd0,
    UNIT_ALU  = 3'd1,
    UNIT_MUL  = 3'd2,
    UNIT_SLD  = 3'd3,
    UNIT_ELEM = 3'd4
  } op_unit;

  localparam int UNIT_CNT = int'(UNIT_ELEM) + 1;

  typedef enum logic [1:0] {
    DISP_IDLE,
    DISP_ISSUE,
    DISP_EXEC
  } disp_state_t;

endpackage

// File: rtl/vproc_dispatch_slot.sv
// One execution-unit slot: IDLE/ISSUE/EXEC tracking plus the vreg read/write
// masks that the instruction occupying the unit still holds.
module vproc_dispatch_slot
  import vproc_pkg::*;
#(
  parameter int ID_W = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [ID_W-1:0] new_id,
  input  logic [31:0]     new_rd,
  input  logic [31:0]     new_wr,
  input  logic            accept,
  input  logic            done,
  input  logic [31:0]     rd_clr,
  input  logic [31:0]     wr_clr,
  output logic            is_idle,
  output logic            is_issue,
  output logic [ID_W-1:0] id,
  output logic [31:0]     pend_rd,
  output logic [31:0]     pend_wr
);

  disp_state_t state, state_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= DISP_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      DISP_IDLE:  if (start)  state_nxt = DISP_ISSUE;
      DISP_ISSUE: if (accept) state_nxt = DISP_EXEC;
      DISP_EXEC:  if (done)   state_nxt = DISP_IDLE;
      default:                state_nxt = DISP_IDLE;
    endcase
  end

  // Clears and done only act in EXEC; done wins over a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id      <= '0;
      pend_rd <= '0;
      pend_wr <= '0;
    end else begin
      case (state)
        DISP_IDLE: begin
          if (start) begin
            id      <= new_id;
            pend_rd <= new_rd;
            pend_wr <= new_wr;
          end
        end
        DISP_EXEC: begin
          if (done) begin
            pend_rd <= '0;
            pend_wr <= '0;
          end else begin
            pend_rd <= pend_rd & ~rd_clr;
            pend_wr <= pend_wr & ~wr_clr;
          end
        end
        default: ;
      endcase
    end
  end

  assign is_idle  = (state == DISP_IDLE);
  assign is_issue = (state == DISP_ISSUE);

endmodule

// File: rtl/vproc_dispatcher.sv
// In-order single-entry dispatcher: holds the head instruction until its
// vreg hazards are resolved and its target unit slot is free, then issues it.
module vproc_dispatcher #(
  parameter int UNIT_CNT = vproc_pkg::UNIT_CNT,
  parameter int ID_W     = 3
) (
  input  logic                  clk_i,
  input  logic                  async_rst_i,
  input  logic                  instr_valid_i,
  output logic                  instr_ready_o,
  input  vproc_pkg::op_unit     instr_unit_i,
  input  logic [ID_W-1:0]       instr_id_i,
  input  logic [31:0]           instr_rd_haz_i,
  input  logic [31:0]           instr_wr_haz_i,
  output logic [UNIT_CNT-1:0]   unit_valid_o,
  input  logic [UNIT_CNT-1:0]   unit_ready_i,
  output logic [ID_W-1:0]       unit_id_o,
  input  logic [UNIT_CNT*32-1:0] unit_rd_clr_i,
  input  logic [UNIT_CNT*32-1:0] unit_wr_clr_i,
  input  logic [UNIT_CNT-1:0]   unit_done_i,
  output logic [31:0]           pend_rd_o,
  output logic [31:0]           pend_wr_o,
  output logic                  stall_haz_o,
  output logic                  busy_o
);
  import vproc_pkg::*;

  logic            head_v;
  op_unit          head_unit;
  logic [ID_W-1:0] head_id;
  logic [31:0]     head_rd, head_wr;

  logic [UNIT_CNT-1:0] slot_idle, slot_issue;
  logic [ID_W-1:0]     slot_id [UNIT_CNT];
  logic [31:0]         slot_rd [UNIT_CNT];
  logic [31:0]         slot_wr [UNIT_CNT];

  logic conflict, issue_block, disp, accept;

  always_comb begin
    pend_rd_o = '0;
    pend_wr_o = '0;
    unit_id_o = '0;
    for (int u = 0; u < UNIT_CNT; u++) begin
      pend_rd_o |= slot_rd[u];
      pend_wr_o |= slot_wr[u];
      unit_id_o |= slot_id[u] & {ID_W{slot_issue[u]}};
    end
  end

  // A slot still waiting for its unit to accept blocks new dispatches, so at
  // most one slot is ever in ISSUE and unit_id_o stays unambiguous.
  assign issue_block = |(slot_issue & ~unit_ready_i);
  assign conflict    = |(head_rd & pend_wr_o) | |(head_wr & pend_wr_o) | |(head_wr & pend_rd_o);
  assign disp        = head_v & ~conflict & slot_idle[head_unit] & ~issue_block;
  assign accept      = instr_valid_i & instr_ready_o;

  assign instr_ready_o = ~head_v | disp;
  assign stall_haz_o   = head_v & conflict;
  assign busy_o        = head_v | ~(&slot_idle);
  assign unit_valid_o  = slot_issue;

  always_ff @(posedge clk_i or posedge async_rst_i) begin
    if (async_rst_i) begin
      head_v    <= 1'b0;
      head_unit <= UNIT_LSU;
      head_id   <= '0;
      head_rd   <= '0;
      head_wr   <= '0;
    end else if (accept) begin
      head_v    <= 1'b1;
      head_unit <= instr_unit_i;
      head_id   <= instr_id_i;
      head_rd   <= instr_rd_haz_i;
      head_wr   <= instr_wr_haz_i;
    end else if (disp) begin
      head_v    <= 1'b0;
    end
  end

  for (genvar u = 0; u < UNIT_CNT; u++) begin : g_slot
    vproc_dispatch_slot #(.ID_W(ID_W)) u_slot (
      .clk      (clk_i),
      .rst      (async_rst_i),
      .start    (disp && (head_unit == 3'(u))),
      .new_id   (head_id),
      .new_rd   (head_rd),
      .new_wr   (head_wr),
      .accept   (unit_ready_i[u]),
      .done     (unit_done_i[u]),
      .rd_clr   (unit_rd_clr_i[u*32 +: 32]),
      .wr_clr   (unit_wr_clr_i[u*32 +: 32]),
      .is_idle  (slot_idle[u]),
      .is_issue (slot_issue[u]),
      .id       (slot_id[u]),
      .pend_rd  (slot_rd[u]),
      .pend_wr  (slot_wr[u])
    );
  end

endmodule

// File: tb/tb_vproc_dispatcher.sv
// Directed hazard scenarios plus random traffic, all checked cycle by cycle
// against a transaction-level model of the dispatcher.
module tb_vproc_dispatcher;
  import vproc_pkg::*;

  localparam int UC = 5;
  localparam int IW = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            instr_valid;
  logic            instr_ready;
  op_unit          instr_unit;
  logic [IW-1:0]   instr_id;
  logic [31:0]     instr_rd, instr_wr;
  logic [UC-1:0]   unit_valid, unit_ready, unit_done;
  logic [IW-1:0]   unit_id;
  logic [UC*32-1:0] rd_clr, wr_clr;
  logic [31:0]     pend_rd, pend_wr;
  logic            stall, busy;

  vproc_dispatcher #(.UNIT_CNT(UC), .ID_W(IW)) dut (
    .clk_i          (clk),
    .async_rst_i    (rst),
    .instr_valid_i  (instr_valid),
    .instr_ready_o  (instr_ready),
    .instr_unit_i   (instr_unit),
    .instr_id_i     (instr_id),
    .instr_rd_haz_i (instr_rd),
    .instr_wr_haz_i (instr_wr),
    .unit_valid_o   (unit_valid),
    .unit_ready_i   (unit_ready),
    .unit_id_o      (unit_id),
    .unit_rd_clr_i  (rd_clr),
    .unit_wr_clr_i  (wr_clr),
    .unit_done_i    (unit_done),
    .pend_rd_o      (pend_rd),
    .pend_wr_o      (pend_wr),
    .stall_haz_o    (stall),
    .busy_o         (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: head entry plus, per unit, "occupied" and "awaiting accept".
  bit          m_hv;
  int          m_hunit;
  logic [IW-1:0] m_hid;
  logic [31:0] m_hrd, m_hwr;
  bit          m_busy [UC];
  bit          m_wait [UC];
  logic [IW-1:0] m_id [UC];
  logic [31:0] m_prd [UC];
  logic [31:0] m_pwr [UC];

  bit            e_ready, e_disp, e_stall, e_busy;
  logic [31:0]   e_pr, e_pw;
  logic [UC-1:0] e_valid;
  logic [IW-1:0] e_id;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hv = 0; m_hunit = 0; m_hid = '0; m_hrd = '0; m_hwr = '0;
    for (int u = 0; u < UC; u++) begin
      m_busy[u] = 0; m_wait[u] = 0; m_id[u] = '0; m_prd[u] = '0; m_pwr[u] = '0;
    end
  endtask

  task automatic model_eval();
    bit blk, conf;
    e_pr = '0; e_pw = '0; e_valid = '0; e_id = '0; e_busy = m_hv; blk = 0;
    for (int u = 0; u < UC; u++) begin
      e_pr |= m_prd[u];
      e_pw |= m_pwr[u];
      if (m_busy[u]) e_busy = 1;
      if (m_wait[u]) begin
        e_valid[u] = 1'b1;
        e_id = m_id[u];
        if (!unit_ready[u]) blk = 1;
      end
    end
    conf    = ((m_hrd & e_pw) != 0) || ((m_hwr & e_pw) != 0) || ((m_hwr & e_pr) != 0);
    e_stall = m_hv && conf;
    e_disp  = m_hv && !conf && !m_busy[m_hunit] && !blk;
    e_ready = !m_hv || e_disp;
  endtask

  task automatic model_update();
    for (int u = 0; u < UC; u++) begin
      if (m_wait[u]) begin
        if (unit_ready[u]) m_wait[u] = 0;
      end else if (m_busy[u]) begin
        if (unit_done[u]) begin
          m_busy[u] = 0; m_prd[u] = '0; m_pwr[u] = '0;
        end else begin
          m_prd[u] &= ~rd_clr[u*32 +: 32];
          m_pwr[u] &= ~wr_clr[u*32 +: 32];
        end
      end
    end
    if (e_disp) begin
      m_busy[m_hunit] = 1; m_wait[m_hunit] = 1;
      m_id[m_hunit] = m_hid; m_prd[m_hunit] = m_hrd; m_pwr[m_hunit] = m_hwr;
    end
    if (instr_valid && e_ready) begin
      m_hv = 1; m_hunit = int'(instr_unit); m_hid = instr_id; m_hrd = instr_rd; m_hwr = instr_wr;
    end else if (e_disp) begin
      m_hv = 0;
    end
  endtask

  // Inputs are set right after a falling edge; step checks and advances one cycle.
  task automatic step();
    #1;
    model_eval();
    check_eq("instr_ready", 32'(instr_ready), 32'(e_ready));
    check_eq("unit_valid",  32'(unit_valid),  32'(e_valid));
    check_eq("unit_id",     32'(unit_id),     32'(e_id));
    check_eq("pend_rd",     pend_rd,          e_pr);
    check_eq("pend_wr",     pend_wr,          e_pw);
    check_eq("stall_haz",   32'(stall),       32'(e_stall));
    check_eq("busy",        32'(busy),        32'(e_busy));
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle_in();
    instr_valid = 0; instr_unit = UNIT_LSU; instr_id = '0; instr_rd = '0; instr_wr = '0;
    unit_ready = '1; unit_done = '0; rd_clr = '0; wr_clr = '0;
  endtask

  task automatic push(input op_unit un, input int id, input logic [31:0] rd, input logic [31:0] wr);
    idle_in();
    instr_valid = 1; instr_unit = un; instr_id = IW'(id); instr_rd = rd; instr_wr = wr;
  endtask

  // Retire everything still executing.
  task automatic drain(input int n);
    for (int c = 0; c < n; c++) begin
      idle_in();
      for (int u = 0; u < UC; u++) unit_done[u] = m_busy[u] && !m_wait[u];
      step();
    end
  endtask

  task automatic reset_check(input string tag);
    check_eq({tag, "_ready"},   32'(instr_ready), 32'd1);
    check_eq({tag, "_valid"},   32'(unit_valid),  32'd0);
    check_eq({tag, "_id"},      32'(unit_id),     32'd0);
    check_eq({tag, "_pend_rd"}, pend_rd,          32'd0);
    check_eq({tag, "_pend_wr"}, pend_wr,          32'd0);
    check_eq({tag, "_stall"},   32'(stall),       32'd0);
    check_eq({tag, "_busy"},    32'(busy),        32'd0);
  endtask

  initial begin
    idle_in();
    model_reset();
    #1;
    reset_check("rst");
    @(negedge clk);
    rst = 0;

    // RAW: ALU writes v4, MUL reads v4.
    push(UNIT_ALU, 1, 32'h0, 32'h10); step();
    push(UNIT_MUL, 2, 32'h10, 32'h0010_0000); step();
    idle_in(); #1 check_eq("raw_stall0", 32'(stall), 32'd1); step();
    idle_in(); #1 check_eq("raw_stall1", 32'(stall), 32'd1); step();
    idle_in(); wr_clr[1*32 + 4] = 1'b1; step();
    idle_in(); #1 check_eq("raw_stall_gone", 32'(stall), 32'd0);
    check_eq("raw_mul_t1", 32'(unit_valid[2]), 32'd0); step();
    idle_in(); #1 check_eq("raw_mul_t2", 32'(unit_valid[2]), 32'd1); step();
    drain(4);

    // WAR: LSU reads v8..v15, ALU writes v10.
    push(UNIT_LSU, 5, 32'h0000_FF00, 32'h0); step();
    push(UNIT_ALU, 6, 32'h0, 32'h400); step();
    idle_in(); #1 check_eq("war_stall", 32'(stall), 32'd1); step();
    idle_in(); rd_clr[0 +: 32] = 32'h0000_FF00; unit_done[0] = 1'b1; step();
    idle_in(); #1 check_eq("war_pend_rd", pend_rd, 32'd0);
    check_eq("war_free", 32'(stall), 32'd0); step();
    idle_in(); #1 check_eq("war_alu_issue", 32'(unit_valid[1]), 32'd1);
    check_eq("war_alu_id", 32'(unit_id), 32'd6); step();
    drain(4);

    // Two independent ALU ops: second waits only on the slot.
    push(UNIT_ALU, 3, 32'h0, 32'h2); step();
    push(UNIT_ALU, 4, 32'h0, 32'h4); step();
    idle_in(); #1 check_eq("alu2_nohaz", 32'(stall), 32'd0); step();
    idle_in(); unit_done[1] = 1'b1; step();
    idle_in(); #1 check_eq("alu2_d1", 32'(unit_valid[1]), 32'd0); step();
    idle_in(); #1 check_eq("alu2_d2", 32'(unit_valid[1]), 32'd1);
    check_eq("alu2_id", 32'(unit_id), 32'd4); step();
    drain(4);

    // Masked ALU op behind ELEM writing v0; MUL queued behind it waits too.
    push(UNIT_ELEM, 1, 32'h0, 32'h1); step();
    push(UNIT_ALU, 2, 32'h1, 32'h8); step();
    push(UNIT_MUL, 3, 32'h0010_0000, 32'h0020_0000); #1
    check_eq("v0_stall", 32'(stall), 32'd1);
    check_eq("v0_inorder", 32'(instr_ready), 32'd0); step();
    push(UNIT_MUL, 3, 32'h0010_0000, 32'h0020_0000); #1
    check_eq("v0_mul_wait", 32'(unit_valid[2]), 32'd0); step();
    idle_in(); unit_done[4] = 1'b1; step();
    drain(6);

    // SLD unit not ready for 5 cycles: request and tag hold.
    push(UNIT_SLD, 5, 32'h0, 32'h0); step();
    push(UNIT_SLD, 6, 32'h0, 32'h0); step();
    for (int c = 0; c < 5; c++) begin
      push(UNIT_LSU, 7, 32'h0, 32'h0); unit_ready[3] = 1'b0; #1
      check_eq("sld_hold_valid", 32'(unit_valid[3]), 32'd1);
      check_eq("sld_hold_id", 32'(unit_id), 32'd5);
      check_eq("sld_full", 32'(instr_ready), 32'd0);
      step();
    end
    drain(8);

    // Reset while LSU, ALU and MUL are executing.
    push(UNIT_LSU, 1, 32'h0, 32'h0); step();
    push(UNIT_ALU, 2, 32'h0, 32'h20); step();
    push(UNIT_MUL, 3, 32'h40, 32'h0); step();
    idle_in(); step();
    idle_in(); step();
    check_eq("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1; #1
    reset_check("midrst");
    model_reset();
    @(negedge clk);
    rst = 0;
    push(UNIT_ALU, 4, 32'h20, 32'h40); step();
    idle_in(); #1 check_eq("post_rst_nohaz", 32'(stall), 32'd0); step();
    idle_in(); #1 check_eq("post_rst_issue", 32'(unit_valid[1]), 32'd1); step();
    drain(4);

    // Random traffic over a small vreg window to provoke hazards.
    for (int c = 0; c < 3000; c++) begin
      idle_in();
      instr_valid = ($urandom_range(0, 3) != 0);
      instr_unit  = op_unit'(3'($urandom_range(0, UC - 1)));
      instr_id    = IW'($urandom);
      instr_rd    = $urandom & $urandom & 32'h0000_00FF;
      instr_wr    = $urandom & $urandom & $urandom & 32'h0000_00FF;
      unit_ready  = UC'($urandom);
      for (int u = 0; u < UC; u++) begin
        if (m_busy[u] && !m_wait[u]) begin
          unit_done[u]       = ($urandom_range(0, 5) == 0);
          rd_clr[u*32 +: 32] = $urandom & $urandom;
          wr_clr[u*32 +: 32] = $urandom & $urandom;
        end
      end
      step();
    end
    drain(10);
    check_eq("end_idle", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule
